// File: rtl/regfile_writeback_queue.sv
// Ordered write-back buffer in front of the register file's single write port.
// Merges load and ALU results, drains one write per cycle, and forwards pending values to decode.
module regfile_writeback_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 3,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       memValid,
  input  logic [REG_NUM_WIDTH-1:0]   memNum,
  input  logic [DATA_WIDTH-1:0]      memData,
  input  logic                       aluValid,
  input  logic [REG_NUM_WIDTH-1:0]   aluNum,
  input  logic [DATA_WIDTH-1:0]      aluData,
  output logic                       enqReady,
  output logic                       wrEnable,
  output logic [REG_NUM_WIDTH-1:0]   wrNum,
  output logic [DATA_WIDTH-1:0]      wrData,
  input  logic [REG_NUM_WIDTH-1:0]   fwdNumA,
  input  logic [REG_NUM_WIDTH-1:0]   fwdNumB,
  output logic                       fwdHitA,
  output logic                       fwdHitB,
  output logic [DATA_WIDTH-1:0]      fwdDataA,
  output logic [DATA_WIDTH-1:0]      fwdDataB,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_NUM_WIDTH-1:0] r_num  [DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [DEPTH];
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [CNT_W-1:0]         r_count;

  logic                     w_mem_acc;
  logic                     w_alu_acc;
  logic                     w_deq;
  logic [1:0]               w_n_enq;
  logic [PTR_W-1:0]         w_alu_slot;

  // Handshake: a source transfers on a cycle where its valid and enqReady are both 1;
  // while enqReady is 0 the source holds its result and valid. enqReady depends only on
  // registered count, so there is room for two entries whenever it is asserted.
  assign enqReady   = (r_count <= CNT_W'(DEPTH - 2));
  assign w_mem_acc  = enqReady && memValid && (memNum != '0);
  assign w_alu_acc  = enqReady && aluValid && (aluNum != '0);
  assign w_n_enq    = {1'b0, w_mem_acc} + {1'b0, w_alu_acc};
  assign w_alu_slot = r_tail + PTR_W'(w_mem_acc);
  assign w_deq      = (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_n_enq);
      r_count <= r_count + CNT_W'(w_n_enq) - CNT_W'(w_deq);
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_mem_acc) begin
      r_num[r_tail]  <= memNum;
      r_data[r_tail] <= memData;
    end
    if (w_alu_acc) begin
      r_num[w_alu_slot]  <= aluNum;
      r_data[w_alu_slot] <= aluData;
    end
  end

  assign wrEnable = w_deq;
  assign wrNum    = w_deq ? r_num[r_head]  : '0;
  assign wrData   = w_deq ? r_data[r_head] : '0;
  assign count    = r_count;

  logic [REG_NUM_WIDTH-1:0] w_fwd_num  [2];
  logic                     w_fwd_hit  [2];
  logic [DATA_WIDTH-1:0]    w_fwd_data [2];

  assign w_fwd_num[0] = fwdNumA;
  assign w_fwd_num[1] = fwdNumB;

  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_fwd_hit[p]  = 1'b0;
      w_fwd_data[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < r_count) && (w_fwd_num[p] != '0) &&
            (r_num[r_head + PTR_W'(i)] == w_fwd_num[p])) begin
          w_fwd_hit[p]  = 1'b1;
          w_fwd_data[p] = r_data[r_head + PTR_W'(i)];
        end
      end
    end
  end

  assign fwdHitA  = w_fwd_hit[0];
  assign fwdDataA = w_fwd_data[0];
  assign fwdHitB  = w_fwd_hit[1];
  assign fwdDataB = w_fwd_data[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: per-cycle vector table, then a dual-enqueue
// backpressure/wrap sequence checked against an expected-write queue.
module tb_regfile_writeback_queue;

  localparam int DW = 32;
  localparam int RW = 3;
  localparam int W  = RW + DW;

  // clock / reset
  logic clk;
  logic rstN;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          memValid, aluValid, enqReady, wrEnable, fwdHitA, fwdHitB;
  logic [RW-1:0] memNum, aluNum, wrNum, fwdNumA, fwdNumB;
  logic [DW-1:0] memData, aluData, wrData, fwdDataA, fwdDataB;
  logic [2:0]    count;

  regfile_writeback_queue #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW), .DEPTH(4)) dut (
    .clk(clk), .rstN(rstN),
    .memValid(memValid), .memNum(memNum), .memData(memData),
    .aluValid(aluValid), .aluNum(aluNum), .aluData(aluData),
    .enqReady(enqReady), .wrEnable(wrEnable), .wrNum(wrNum), .wrData(wrData),
    .fwdNumA(fwdNumA), .fwdNumB(fwdNumB),
    .fwdHitA(fwdHitA), .fwdHitB(fwdHitB), .fwdDataA(fwdDataA), .fwdDataB(fwdDataB),
    .count(count)
  );

  typedef struct {
    logic          rst_n;
    logic          mv;
    logic [RW-1:0] mn;
    logic [DW-1:0] md;
    logic          av;
    logic [RW-1:0] an;
    logic [DW-1:0] ad;
    logic [RW-1:0] fa;
    logic [RW-1:0] fb;
    logic          e_rdy;
    logic          e_we;
    logic [RW-1:0] e_wn;
    logic [DW-1:0] e_wd;
    logic          e_ha;
    logic [DW-1:0] e_da;
    logic          e_hb;
    logic [DW-1:0] e_db;
    logic [2:0]    e_cnt;
  } vec_t;

  vec_t          tbl[$];
  logic [W-1:0]  exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic vec_t mk(input logic r, mv, input logic [RW-1:0] mn, input logic [DW-1:0] md,
                              input logic av, input logic [RW-1:0] an, input logic [DW-1:0] ad,
                              input logic [RW-1:0] fa, fb, input logic rdy, we,
                              input logic [RW-1:0] wn, input logic [DW-1:0] wd,
                              input logic ha, input logic [DW-1:0] da,
                              input logic hb, input logic [DW-1:0] db, input logic [2:0] cnt);
    vec_t v;
    v.rst_n = r; v.mv = mv; v.mn = mn; v.md = md; v.av = av; v.an = an; v.ad = ad;
    v.fa = fa; v.fb = fb; v.e_rdy = rdy; v.e_we = we; v.e_wn = wn; v.e_wd = wd;
    v.e_ha = ha; v.e_da = da; v.e_hb = hb; v.e_db = db; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    memValid = 1'b0; memNum = '0; memData = '0;
    aluValid = 1'b0; aluNum = '0; aluData = '0;
    fwdNumA  = '0;   fwdNumB = '0;
  endtask

  // scoreboard: each issued write must match the oldest expected write
  task automatic mon_write();
    logic [W-1:0] e;
    if (wrEnable) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected_write: got r%0d=0x%0h, expected no write", wrNum, wrData);
      end else begin
        e = exp_q.pop_front();
        check("sb_wrNum", DW'(wrNum), DW'(e[W-1:DW]));
        check("sb_wrData", wrData, e[DW-1:0]);
      end
    end
  endtask

  initial begin
    int     k;
    int     max_cnt;
    logic   saw_busy;

    rstN = 1'b0;
    drive_idle();

    //            rst mv mn  md      av an  ad      fa fb  rdy we wn wd      ha da      hb db      cnt
    // single ALU write + forward
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      3, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    tbl.push_back(mk(1, 0, 0, 0,      1, 3, 'h11,   3, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      3, 0,  1, 1, 3, 'h11,   1, 'h11,   0, 0,      1));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      3, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    // dual enqueue to same register: mem older, ALU youngest
    tbl.push_back(mk(1, 1, 2, 'hAA,   1, 2, 'hBB,   2, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      2, 0,  1, 1, 2, 'hAA,   1, 'hBB,   0, 0,      2));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      2, 0,  1, 1, 2, 'hBB,   1, 'hBB,   0, 0,      1));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      2, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    // r0 destination discarded; r0 lookup misses
    tbl.push_back(mk(1, 1, 4, 'h66,   1, 0, 'h55,   0, 4,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 4,  1, 1, 4, 'h66,   0, 0,      1, 'h66,   1));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 4,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    // back-to-back singles to r1
    tbl.push_back(mk(1, 0, 0, 0,      1, 1, 1,      0, 1,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    tbl.push_back(mk(1, 0, 0, 0,      1, 1, 2,      0, 1,  1, 1, 1, 1,      0, 0,      1, 1,      1));
    tbl.push_back(mk(1, 0, 0, 0,      1, 1, 3,      0, 1,  1, 1, 1, 2,      0, 0,      1, 2,      1));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 1,  1, 1, 1, 3,      0, 0,      1, 3,      1));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 1,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    // three pending r5 values: youngest wins among multiple matches
    tbl.push_back(mk(1, 1, 5, 'h50,   1, 5, 'h51,   5, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    tbl.push_back(mk(1, 0, 0, 0,      1, 5, 'h52,   5, 0,  1, 1, 5, 'h50,   1, 'h51,   0, 0,      2));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      5, 6,  1, 1, 5, 'h51,   1, 'h52,   0, 0,      2));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      5, 0,  1, 1, 5, 'h52,   1, 'h52,   0, 0,      1));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      5, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    // fill to 3, then reset while both sources are valid
    tbl.push_back(mk(1, 1, 1, 'hA1,   1, 2, 'hA2,   0, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    tbl.push_back(mk(1, 1, 3, 'hA3,   1, 4, 'hA4,   4, 0,  1, 1, 1, 'hA1,   0, 0,      0, 0,      2));
    tbl.push_back(mk(0, 1, 5, 'hA5,   1, 6, 'hA6,   4, 0,  0, 1, 2, 'hA2,   1, 'hA4,   0, 0,      3));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      4, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 0,  1, 0, 0, 0,      0, 0,      0, 0,      0));

    repeat (2) @(posedge clk);

    // table-driven vectors: drive at negedge, compare 1 time unit later, commit at posedge
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rstN     = tbl[i].rst_n;
      memValid = tbl[i].mv; memNum = tbl[i].mn; memData = tbl[i].md;
      aluValid = tbl[i].av; aluNum = tbl[i].an; aluData = tbl[i].ad;
      fwdNumA  = tbl[i].fa; fwdNumB = tbl[i].fb;
      #1;
      check($sformatf("v%0d enqReady", i), DW'(enqReady), DW'(tbl[i].e_rdy));
      check($sformatf("v%0d wrEnable", i), DW'(wrEnable), DW'(tbl[i].e_we));
      check($sformatf("v%0d wrNum", i),    DW'(wrNum),    DW'(tbl[i].e_wn));
      check($sformatf("v%0d wrData", i),   wrData,        tbl[i].e_wd);
      check($sformatf("v%0d fwdHitA", i),  DW'(fwdHitA),  DW'(tbl[i].e_ha));
      check($sformatf("v%0d fwdDataA", i), fwdDataA,      tbl[i].e_da);
      check($sformatf("v%0d fwdHitB", i),  DW'(fwdHitB),  DW'(tbl[i].e_hb));
      check($sformatf("v%0d fwdDataB", i), fwdDataB,      tbl[i].e_db);
      check($sformatf("v%0d count", i),    DW'(count),    DW'(tbl[i].e_cnt));
    end

    // dual enqueue every cycle with held results under backpressure, across pointer wrap
    rstN     = 1'b1;
    k        = 0;
    max_cnt  = 0;
    saw_busy = 1'b0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      @(negedge clk);
      memValid = 1'b1; memNum = RW'(k + 1); memData = DW'(32'h100 + k);
      aluValid = 1'b1; aluNum = RW'(k + 4); aluData = DW'(32'h200 + k);
      fwdNumA  = '0;   fwdNumB = '0;
      #1;
      mon_write();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (!enqReady) saw_busy = 1'b1;
      if (enqReady) begin
        exp_q.push_back({memNum, memData});
        exp_q.push_back({aluNum, aluData});
        k++;
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive_idle();
      #1;
      mon_write();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (count == '0) break;
    end
    check("seq pairs_accepted", DW'(k), 32'd4);
    check("seq count_drained",  DW'(count), 32'd0);
    check("seq sb_leftover",    DW'(exp_q.size()), 32'd0);
    check("seq peak_count",     DW'(max_cnt), 32'd3);
    check("seq enqReady_low",   DW'(saw_busy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
